// File: rtl/ex_pkg.sv
// Shared types for the execute result stage: flag word layout, forwarded payload, reset flags.
package ex_pkg;

    localparam int unsigned EX_N  = 32;
    localparam int unsigned EX_RW = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef struct packed {
        logic [EX_N-1:0]  result;
        logic [EX_RW-1:0] rd;
        logic             we;
    } ex_payload_t;

    localparam nzcv_t NZCV_RESET = '0;

endpackage

// File: rtl/ex_result_stage_skid_buffer.sv
// Generic 2-entry valid/ready buffer: main register drives the outputs, skid register
// absorbs one extra entry so in_ready can be a pure function of registered state.
module skid_buffer
    import ex_pkg::*;
#(
    parameter type T = ex_payload_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_valid, skid_valid;
    logic main_valid_d, skid_valid_d;
    logic load_main_in, load_main_skid, load_skid;
    logic accept, drain;
    T     main_q, skid_q;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_q;

    always_comb begin
        accept         = in_valid && !skid_valid;
        drain          = main_valid && out_ready;
        main_valid_d   = main_valid;
        skid_valid_d   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (clear) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid) begin
            // Skid full implies no accept this cycle; only a drain can move things.
            if (drain) begin
                load_main_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || drain) begin
                load_main_in = 1'b1;
                main_valid_d = 1'b1;
            end else begin
                load_skid    = 1'b1;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            if (load_main_in)   main_q <= in_data;
            if (load_main_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-to-memory result stage: buffers result/rd/we through a skid buffer and owns NZCV.
// Optional FLAG_BYPASS_EN: nzcv shows accepted incoming flags combinationally in the same cycle.
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int unsigned N  = EX_N,
    parameter int unsigned RW = EX_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_result,
    input  logic          in_z,
    input  logic          in_c,
    input  logic          in_v,
    input  logic          in_n,
    input  logic          in_set_flags,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic [3:0]    nzcv
);

    typedef struct packed {
        logic [N-1:0]  result;
        logic [RW-1:0] rd;
        logic          we;
    } payload_t;

    payload_t in_pl, out_pl;
    nzcv_t    nzcv_q, nzcv_in, nzcv_out;
    logic     accept, flag_wr;

    assign in_pl   = '{result: in_result, rd: in_rd, we: in_we};
    assign nzcv_in = '{n: in_n, z: in_z, c: in_c, v: in_v};
    assign accept  = in_valid && in_ready && !flush;
    assign flag_wr = accept && in_set_flags;

    skid_buffer #(.T(payload_t)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .in_valid  (in_valid && !flush),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    assign out_result = out_pl.result;
    assign out_rd     = out_pl.rd;
    assign out_we     = out_pl.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q <= NZCV_RESET;
        end else if (flag_wr) begin
            nzcv_q <= nzcv_in;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign nzcv_out = flag_wr ? nzcv_in : nzcv_q;
`else
    assign nzcv_out = nzcv_q;
`endif

    assign nzcv = nzcv_out;

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: queue-based reference model plus directed literal checks.
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_z, in_c, in_v, in_n, in_set_flags;
    logic [3:0]  in_rd;
    logic        in_we, flush;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [3:0]  nzcv;

    always #5 clk = ~clk;

    ex_result_stage #(.N(32), .RW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_z         (in_z),
        .in_c         (in_c),
        .in_v         (in_v),
        .in_n         (in_n),
        .in_set_flags (in_set_flags),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .nzcv         (nzcv)
    );

    typedef struct {
        logic [31:0] r;
        logic [3:0]  rd;
        logic        we;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_nzcv;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_nzcv();
        logic [3:0] e;
        e = m_nzcv;
`ifdef FLAG_BYPASS_EN
        if (rst_n && in_valid && q.size() < 2 && !flush && in_set_flags)
            e = {in_n, in_z, in_c, in_v};
`endif
        return e;
    endfunction

    task automatic model_compare();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_result", 64'(out_result), 64'(q[0].r));
            chk("out_rd", 64'(out_rd), 64'(q[0].rd));
            chk("out_we", 64'(out_we), 64'(q[0].we));
        end
        chk("nzcv", 64'(nzcv), 64'(exp_nzcv()));
    endtask

    // f is {n,z,c,v}
    task automatic drive(input logic iv, input logic [31:0] r, input logic [3:0] f,
                         input logic sf, input logic [3:0] rd, input logic we,
                         input logic fl, input logic ordy);
        @(negedge clk);
        in_valid = iv; in_result = r; {in_n, in_z, in_c, in_v} = f;
        in_set_flags = sf; in_rd = rd; in_we = we; flush = fl; out_ready = ordy;
        #1;
        model_compare();
    endtask

    task automatic commit();
        bit   drn, acc;
        ent_t e;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_nzcv = 4'b0000;
        end else if (flush) begin
            q.delete();
        end else begin
            drn = out_ready && q.size() > 0;
            acc = in_valid && q.size() < 2;
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.r = in_result; e.rd = in_rd; e.we = in_we;
                q.push_back(e);
                if (in_set_flags) m_nzcv = {in_n, in_z, in_c, in_v};
            end
        end
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [31:0] r, input logic [3:0] f,
                       input logic sf, input logic fl, input logic ordy);
        drive(iv, r, f, sf, r[3:0], r[0], fl, ordy);
        commit();
    endtask

    task automatic rand_cyc();
        cyc(logic'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 9) < 6));
    endtask

    task automatic reset_literal(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_nzcv"}, 64'(nzcv), 64'd0);
        chk({tag, "_out_result"}, 64'(out_result), 64'd0);
        chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
        chk({tag, "_out_we"}, 64'(out_we), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; {in_n, in_z, in_c, in_v} = 4'b0;
        in_set_flags = 1'b0; in_rd = '0; in_we = 1'b0; flush = 1'b0; out_ready = 1'b0;
        m_nzcv = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset_literal("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 32'(k), 4'b0000, 1'b0, 1'b0, 1'b1);
            chk("stream_result", 64'(out_result), 64'(k));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        cyc(1'b0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("stream_empty", 64'(out_valid), 64'd0);

        // Backpressure
        cyc(1'b1, 32'hA, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        cyc(1'b1, 32'hB, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready2", 64'(in_ready), 64'd0);
        cyc(1'b1, 32'hC, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_hold", 64'(out_result), 64'hA);
        cyc(1'b0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_second", 64'(out_result), 64'hB);
        chk("bp_ready3", 64'(in_ready), 64'd1);
        cyc(1'b0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flags
        cyc(1'b1, 32'h0, 4'b0100, 1'b1, 1'b0, 1'b1);
        chk("flag_set", 64'(nzcv), 64'b0100);
        cyc(1'b1, 32'h5, 4'b1000, 1'b0, 1'b0, 1'b1);
        chk("flag_hold", 64'(nzcv), 64'b0100);

        // Bypass vs registered flag timing
        drive(1'b1, 32'h7, 4'b0010, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
`ifdef FLAG_BYPASS_EN
        chk("bypass_same", 64'(nzcv), 64'b0010);
`else
        chk("bypass_same", 64'(nzcv), 64'b0100);
`endif
        commit();
        chk("bypass_next", 64'(nzcv), 64'b0010);

        // Flush with main and skid occupied
        cyc(1'b1, 32'h11, 4'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 4'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 4'b0001, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
        chk("flush_nzcv_same", 64'(nzcv), 64'b0010);
        commit();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_nzcv", 64'(nzcv), 64'b0010);

        // Flush with only main occupied and stage ready for a flag-setter
        cyc(1'b1, 32'h44, 4'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h55, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("flush2_valid", 64'(out_valid), 64'd0);
        chk("flush2_nzcv", 64'(nzcv), 64'b0010);

        repeat (400) rand_cyc();

        // Asynchronous reset mid-stream with both entries held
        cyc(1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hCAFE_F00D, 4'b1010, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0; flush = 1'b0; in_set_flags = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_literal("midreset");
        q.delete();
        m_nzcv = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        repeat (200) rand_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
